// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain clock/data enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk100MHz,
  input  logic       resetN,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       txBusy,
  output logic       txDone,
  output logic       txAck,
  output logic       txError,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkOE,
  output logic       ps2DataOE
);
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 18) ? $clog2(TIMEOUT_CYCLES + 1) : 18;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAITIDLE} state_t;
  state_t state;
  logic [1:0] clk_sync, dat_sync;
  logic clk_prev, fall, watched, timeout;
  logic [8:0] shreg;
  logic [3:0] bit_cnt;
  logic [TW-1:0] timer;
  always_ff @(posedge clk100MHz or negedge resetN)
    if (!resetN) {clk_sync, dat_sync, clk_prev} <= '1;
    else begin
      clk_sync <= {clk_sync[0], ps2ClkIn};
      dat_sync <= {dat_sync[0], ps2DataIn};
      clk_prev <= clk_sync[1];
    end
  assign fall = clk_prev & ~clk_sync[1];
  assign watched = state inside {REQ, SHIFT, ACK, WAITIDLE};
  assign timeout = watched && timer == TW'(TIMEOUT_CYCLES - 1);
  // Our own inhibit pull on the clock line must not restart the inhibit count
  always_ff @(posedge clk100MHz or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      {txBusy, txDone, txAck, txError, ps2ClkOE, ps2DataOE} <= '0;
      shreg <= '0;
      bit_cnt <= '0;
      timer <= '0;
    end else begin
      txDone <= 1'b0;
      txError <= 1'b0;
      timer <= (state == IDLE || (fall && state != INHIBIT)) ? '0 : timer + 1'b1;
      if (timeout) begin
        state <= IDLE;
        {txBusy, txAck, ps2ClkOE, ps2DataOE} <= '0;
        txDone <= 1'b1;
        txError <= 1'b1;
      end else case (state)
        IDLE: if (txStart && !txDone) begin
          state <= INHIBIT;
          shreg <= {~^txData, txData};
          txAck <= 1'b0;
          txBusy <= 1'b1;
          ps2ClkOE <= 1'b1;
        end
        INHIBIT: if (timer == TW'(INHIBIT_CYCLES - 1)) begin
          state <= REQ;
          ps2DataOE <= 1'b1;
          timer <= '0;
        end
        REQ: begin
          state <= SHIFT;
          ps2ClkOE <= 1'b0;
          bit_cnt <= '0;
          timer <= '0;
        end
        SHIFT: if (fall) begin
          ps2DataOE <= (bit_cnt != 4'd9) & ~shreg[0];
          shreg <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          state <= bit_cnt == 4'd9 ? ACK : SHIFT;
        end
        ACK: if (fall) begin
          state <= WAITIDLE;
          txAck <= ~dat_sync[1];
        end
        WAITIDLE: if (clk_sync[1] && dat_sync[1]) begin
          state <= IDLE;
          txBusy <= 1'b0;
          txDone <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
